// File: rtl/vga_pkg.sv
// Shared raster constants for the 800x600 @ 60 Hz pixel pipeline.
// The draw stages import the same values so that all coordinates agree.
package vga_pkg;

  localparam int unsigned COUNT_W = 11;

  typedef logic [COUNT_W-1:0] count_t;

  localparam count_t H_ACTIVE = 11'd800;
  localparam count_t H_FP     = 11'd40;
  localparam count_t H_SYNC   = 11'd128;
  localparam count_t H_BP     = 11'd88;

  localparam count_t V_ACTIVE = 11'd600;
  localparam count_t V_FP     = 11'd1;
  localparam count_t V_SYNC   = 11'd4;
  localparam count_t V_BP     = 11'd23;

  localparam logic SYNC_POL = 1'b1;

  localparam count_t H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam count_t V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam count_t HS_START = H_ACTIVE + H_FP;
  localparam count_t HS_END   = HS_START + H_SYNC;
  localparam count_t VS_START = V_ACTIVE + V_FP;
  localparam count_t VS_END   = VS_START + V_SYNC;

  // Half-open window test: lo <= v < hi.
  function automatic logic in_window(input count_t v, input count_t lo, input count_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_if.sv
// Raster bundle passed between the timing generator and the draw stages.
interface vga_if;
  import vga_pkg::*;

  count_t      hcount;
  count_t      vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing.sv
// Free-running VGA raster generator: pixel/line counters, sync, blanking
// and a one-cycle frame tick, all registered and mutually aligned.
module vga_timing
  import vga_pkg::count_t;
#(
  parameter count_t H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter count_t H_FP     = vga_pkg::H_FP,
  parameter count_t H_SYNC   = vga_pkg::H_SYNC,
  parameter count_t H_BP     = vga_pkg::H_BP,
  parameter count_t V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter count_t V_FP     = vga_pkg::V_FP,
  parameter count_t V_SYNC   = vga_pkg::V_SYNC,
  parameter count_t V_BP     = vga_pkg::V_BP,
  parameter logic   SYNC_POL = vga_pkg::SYNC_POL
) (
  input  logic clk,
  input  logic rst_n,
  vga_if.out   vga_out,
  output logic frame_tick
);

  localparam count_t H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam count_t V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam count_t HS_START = H_ACTIVE + H_FP;
  localparam count_t HS_END   = HS_START + H_SYNC;
  localparam count_t VS_START = V_ACTIVE + V_FP;
  localparam count_t VS_END   = VS_START + V_SYNC;

  count_t hcount;
  count_t vcount;
  count_t h_next;
  count_t v_next;
  logic   h_last;
  logic   v_last;
  logic   hsync;
  logic   vsync;
  logic   hblnk;
  logic   vblnk;
  logic   tick;

  always_comb begin
    h_last = (hcount == H_TOTAL - 1'b1);
    v_last = (vcount == V_TOTAL - 1'b1);
    h_next = h_last ? '0 : hcount + 1'b1;
    v_next = vcount;
    if (h_last) begin
      v_next = v_last ? '0 : vcount + 1'b1;
    end
  end

  // Decode from the next counter values so every flag lines up with the
  // coordinates it describes; vsync can only move when v_next moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount <= '0;
      vcount <= '0;
      hsync  <= ~SYNC_POL;
      vsync  <= ~SYNC_POL;
      hblnk  <= 1'b0;
      vblnk  <= 1'b0;
      tick   <= 1'b0;
    end else begin
      hcount <= h_next;
      vcount <= v_next;
      hsync  <= vga_pkg::in_window(h_next, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync  <= vga_pkg::in_window(v_next, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
      hblnk  <= (h_next >= H_ACTIVE);
      vblnk  <= (v_next >= V_ACTIVE);
      tick   <= (h_next == '0) && (v_next == '0);
    end
  end

  assign vga_out.hcount = hcount;
  assign vga_out.vcount = vcount;
  assign vga_out.hsync  = hsync;
  assign vga_out.vsync  = vsync;
  assign vga_out.hblnk  = hblnk;
  assign vga_out.vblnk  = vblnk;
  assign vga_out.rgb    = '0;
  assign frame_tick     = tick;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full-width lines, a short 16-line frame so whole
// frames and the frame tick fit in a short run.
module tb_vga_timing;

  localparam int LINE     = 1056;
  localparam int VTOT     = 16;
  localparam int FRAME    = LINE * VTOT;
  localparam int HB_START = 800;
  localparam int HS_START = 840;
  localparam int HS_END   = 968;
  localparam int VB_START = 8;
  localparam int VS_START = 9;
  localparam int VS_END   = 13;

  logic clk;
  logic rst_n;
  logic frame_tick;

  vga_if vif();

  vga_timing #(
    .V_ACTIVE (11'd8),
    .V_FP     (11'd1),
    .V_SYNC   (11'd4),
    .V_BP     (11'd3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vga_out    (vif),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int k;
    int h;
    int v;
    bit hs;
    bit vs;
    bit hb;
    bit vb;
    bit tk;
  } vec_t;

  vec_t tbl[$];

  int vectors = 0;
  int miscompares = 0;
  int k = 0;
  int since_line = 0;
  int since_tick = 0;
  int hs_len = 0;
  bit mon_valid = 0;
  bit p_hs, p_vs, p_hb, p_vb;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at k=%0d: got %0d, want %0d", name, k, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int h, input int v,
                           input bit hs, input bit vs, input bit hb,
                           input bit vb, input bit tk);
    chk({tag, "/hcount"}, int'(vif.hcount), h);
    chk({tag, "/vcount"}, int'(vif.vcount), v);
    chk({tag, "/hsync"},  int'(vif.hsync), int'(hs));
    chk({tag, "/vsync"},  int'(vif.vsync), int'(vs));
    chk({tag, "/hblnk"},  int'(vif.hblnk), int'(hb));
    chk({tag, "/vblnk"},  int'(vif.vblnk), int'(vb));
    chk({tag, "/rgb"},    int'(vif.rgb), 0);
    chk({tag, "/tick"},   int'(frame_tick), int'(tk));
  endtask

  task automatic add(input int kk, input int h, input int v, input bit hs,
                     input bit vs, input bit hb, input bit vb, input bit tk);
    vec_t e;
    e.k = kk; e.h = h; e.v = v; e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb; e.tk = tk;
    tbl.push_back(e);
  endtask

  // One clock, sampled 1 time unit after the edge, with running checks on
  // edges, periods and invariants.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst_n) k++;
    chk("invariant", {31'd0, (vif.hcount < 11'd1056) && (vif.vcount < 11'd16) &&
                              (vif.rgb == 12'd0) && (!vif.hsync || vif.hblnk)}, 1);
    if (!rst_n) begin
      mon_valid  = 0;
      since_line = 0;
      since_tick = 0;
      hs_len     = 0;
    end else begin
      since_line++;
      since_tick++;
      if (vif.hsync) hs_len++;
      if (mon_valid) begin
        if (vif.hblnk && !p_hb) chk("hblnk_rise_h", int'(vif.hcount), HB_START);
        if (!vif.hblnk && p_hb) chk("hblnk_fall_h", int'(vif.hcount), 0);
        if (vif.hsync && !p_hs) chk("hsync_rise_h", int'(vif.hcount), HS_START);
        if (!vif.hsync && p_hs) begin
          chk("hsync_fall_h", int'(vif.hcount), HS_END);
          chk("hsync_len", hs_len, HS_END - HS_START);
          hs_len = 0;
        end
        if (vif.vsync != p_vs) chk("vsync_edge_h", int'(vif.hcount), 0);
        if (vif.vsync && !p_vs) chk("vsync_rise_v", int'(vif.vcount), VS_START);
        if (!vif.vsync && p_vs) chk("vsync_fall_v", int'(vif.vcount), VS_END);
        if (vif.vblnk && !p_vb) chk("vblnk_rise_v", int'(vif.vcount), VB_START);
        if (!vif.vblnk && p_vb) chk("vblnk_fall_v", int'(vif.vcount), 0);
      end
      if (vif.hcount == 11'd0) begin
        chk("line_period", since_line, LINE);
        since_line = 0;
      end
      if (frame_tick || since_tick == FRAME) begin
        chk("tick_present", int'(frame_tick), 1);
        chk("tick_period", since_tick, FRAME);
        chk("tick_pos", int'({vif.hcount, vif.vcount}), 0);
        since_tick = 0;
      end
      mon_valid = 1;
    end
    p_hs = vif.hsync;
    p_vs = vif.vsync;
    p_hb = vif.hblnk;
    p_vb = vif.vblnk;
  endtask

  initial begin
    //   k      h     v   hs vs hb vb tk
    add(1,      1,    0,  0, 0, 0, 0, 0);
    add(799,    799,  0,  0, 0, 0, 0, 0);
    add(800,    800,  0,  0, 0, 1, 0, 0);
    add(839,    839,  0,  0, 0, 1, 0, 0);
    add(840,    840,  0,  1, 0, 1, 0, 0);
    add(967,    967,  0,  1, 0, 1, 0, 0);
    add(968,    968,  0,  0, 0, 1, 0, 0);
    add(1055,   1055, 0,  0, 0, 1, 0, 0);
    add(1056,   0,    1,  0, 0, 0, 0, 0);
    add(8447,   1055, 7,  0, 0, 1, 0, 0);
    add(8448,   0,    8,  0, 0, 0, 1, 0);
    add(9503,   1055, 8,  0, 0, 1, 1, 0);
    add(9504,   0,    9,  0, 1, 0, 1, 0);
    add(10344,  840,  9,  1, 1, 1, 1, 0);
    add(13727,  1055, 12, 0, 1, 1, 1, 0);
    add(13728,  0,    13, 0, 0, 0, 1, 0);
    add(16895,  1055, 15, 0, 0, 1, 1, 0);
    add(16896,  0,    0,  0, 0, 0, 0, 1);
    add(16897,  1,    0,  0, 0, 0, 0, 0);
    add(33791,  1055, 15, 0, 0, 1, 1, 0);
    add(33792,  0,    0,  0, 0, 0, 0, 1);

    rst_n = 1'b0;
    #2;
    check_out("reset_async", 0, 0, 0, 0, 0, 0, 0);
    repeat (10) step();
    check_out("reset_held", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    k = 0;

    foreach (tbl[i]) begin
      while (k < tbl[i].k) step();
      check_out($sformatf("vec%0d", i), tbl[i].h, tbl[i].v, tbl[i].hs,
                tbl[i].vs, tbl[i].hb, tbl[i].vb, tbl[i].tk);
    end

    // Mid-frame asynchronous reset at line 5, pixel 500.
    while (k < 2 * FRAME + 5 * LINE + 500) step();
    check_out("pre_reset", 500, 5, 0, 0, 0, 0, 0);
    #5 rst_n = 1'b0;
    #1 check_out("async_mid", 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    check_out("mid_held", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    k = 0;
    step();
    check_out("restart", 1, 0, 0, 0, 0, 0, 0);
    while (k < LINE) step();
    check_out("restart_line", 0, 1, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
